memory_interface: RTL
=====================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: bus wait cycles before a request is abandoned; legal range 1..65535.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Port list follows.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 memory_enable  input  1  core request strobe, sampled only while memory_ready=1.
REQ-006 memory_command  input  1  0 read, 1 write.
REQ-007 memory_address  input  32  byte address.
REQ-008 memory_write_data  input  32  store data, already lane-aligned.
REQ-009 memory_write_strobe  input  4  byte-lane enables for writes.
REQ-010 memory_ready  output  1  block can accept a request this cycle.
REQ-011 memory_valid  output  1  one-cycle completion pulse.
REQ-012 memory_read_data  output  32  last read result.
REQ-013 memory_fault  output  1  completion was an access fault; valid with memory_valid.
REQ-014 bus_request  output  1  external transaction pending.
REQ-015 bus_write  output  1  transaction is a write.
REQ-016 bus_address  output  32  word address {addr[31:2],2'b00}.
REQ-017 bus_write_data  output  32  write data.
REQ-018 bus_strobe  output  4  byte enables; 4'b1111 for reads.
REQ-019 bus_ack  input  1  transaction complete.
REQ-020 bus_error  input  1  transaction failed; meaningful only with bus_ack.
REQ-021 bus_read_data  input  32  read data; meaningful with bus_ack on a read.

Function
REQ-022 The FSM SHALL have three states: IDLE, REQUEST and DONE.
REQ-023 memory_ready SHALL equal (state==IDLE); it SHALL be 0 in REQUEST and DONE, so a core that holds memory_enable high never double-issues.
REQ-024 In IDLE, memory_enable=1 SHALL latch command, address, write data and strobe into internal registers and move to REQUEST at the next edge.
REQ-025 bus_request SHALL be 1 exactly while in REQUEST.
REQ-026 bus_write, bus_address, bus_write_data and bus_strobe SHALL come from the latched registers and stay stable for the whole REQUEST interval.
REQ-027 In REQUEST, a wait counter SHALL increment each cycle with bus_ack=0, starting at 0 on entry.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 with bus_ack=0, the block SHALL go to DONE with fault=1.
REQ-029 In REQUEST, bus_ack=1 SHALL move to DONE with fault=bus_error.
REQ-030 On a read with bus_ack=1 and bus_error=0, memory_read_data SHALL capture bus_read_data.
REQ-031 Writes, faulted reads and timeouts SHALL leave memory_read_data unchanged.
REQ-032 bus_ack and the timeout in the same cycle: ack SHALL win.
REQ-033 bus_ack and bus_error in the same cycle: the completion SHALL be a fault and read data SHALL NOT be captured.
REQ-034 DONE SHALL last exactly one cycle, assert memory_valid=1 and memory_fault=stored fault, then return to IDLE.
REQ-035 memory_fault SHALL be 0 whenever memory_valid=0.
REQ-036 bus_ack or bus_error seen in IDLE or DONE SHALL be ignored, with no state or data change.
REQ-037 Latency: accept at edge N gives bus_request from cycle N+1; ack in cycle M gives memory_valid in cycle M+1; minimum accept-to-valid is 2 cycles.
REQ-038 The wait counter SHALL be 16 bits and SHALL NOT wrap, because REQUEST is left at TIMEOUT_CYCLES-1.

Reset
REQ-039 While reset=1, asynchronously: state=IDLE, bus_request=0, memory_valid=0, memory_fault=0, memory_read_data=0, latched registers=0, counter=0.
REQ-040 Reset asserted mid-REQUEST SHALL drop bus_request immediately, without waiting for a clock edge; no completion pulse SHALL follow.
REQ-041 After reset deasserts, memory_ready SHALL be 1 in the first cycle.

Verification
REQ-042 Read, 0-wait: enable, cmd=0, addr=0x1003; bus_ack next cycle with data 0xDEADBEEF -> bus_address=0x1000, strobe=1111; valid one cycle later with read_data=0xDEADBEEF, fault=0.
REQ-043 Write, 3 waits: cmd=1, addr=0x2000, data=0x12345678, strobe=0011; ack on the 4th REQUEST cycle -> bus fields stable throughout; valid=1, fault=0; read_data unchanged.
REQ-044 Timeout: TIMEOUT_CYCLES=4, bus_ack never asserted -> bus_request high exactly 4 cycles; valid=1, fault=1; read_data unchanged.
REQ-045 Error and race: bus_ack=1 with bus_error=1 -> fault=1, no capture; separately, ack on the timeout cycle -> fault=0.
REQ-046 Held enable and reset: memory_enable held high over two requests -> exactly two bus transactions, ready=0 between them; reset pulsed mid-REQUEST -> bus_request=0 immediately, no valid pulse, ready=1 after release.

Source files
------------

// File: rtl/memory_interface.sv
// memory_interface
//   Bridges a single-outstanding core memory request onto a simple
//   request/ack external bus. Each accepted request becomes exactly one
//   bus transaction. That transaction ends on bus_ack or after
//   TIMEOUT_CYCLES wait cycles, and is followed by a one-cycle
//   completion pulse to the core.
//
// Parameters
//   TIMEOUT_CYCLES      bus wait cycles before a request is abandoned (1..65535)
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   memory_enable       core request strobe, sampled only while memory_ready=1
//   memory_command      0 read, 1 write
//   memory_address      byte address
//   memory_write_data   lane-aligned store data
//   memory_write_strobe byte-lane enables for writes
//   memory_ready        block can accept a request this cycle
//   memory_valid        one-cycle completion pulse
//   memory_read_data    last successful read result
//   memory_fault        completion was an access fault (qualified by memory_valid)
//   bus_request         external transaction pending
//   bus_write           transaction is a write
//   bus_address         word-aligned address
//   bus_write_data      write data
//   bus_strobe          byte enables (all ones for reads)
//   bus_ack             transaction complete
//   bus_error           transaction failed (qualified by bus_ack)
//   bus_read_data       read data (qualified by bus_ack on a read)
module memory_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    input  logic [3:0]  memory_write_strobe,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] memory_read_data,
    output logic        memory_fault,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_strobe,
    input  logic        bus_ack,
    input  logic        bus_error,
    input  logic [31:0] bus_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Last value the wait counter reaches before the request is abandoned.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        cmd_q,   cmd_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q,  strb_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (memory_enable) begin
                    cmd_d   = memory_command;
                    addr_d  = {memory_address[31:2], 2'b00};
                    wdata_d = memory_write_data;
                    // Reads always fetch the whole word.
                    strb_d  = memory_command ? memory_write_strobe : 4'b1111;
                    cnt_d   = '0;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                // Ack is checked first so an ack on the last wait cycle
                // completes normally instead of timing out.
                if (bus_ack) begin
                    fault_d = bus_error;
                    if (!cmd_q && !bus_error) begin
                        rdata_d = bus_read_data;
                    end
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from state alone so that an
    // asynchronous reset removes bus_request without waiting for an edge.
    assign memory_ready     = (state_q == IDLE);
    assign bus_request      = (state_q == REQUEST);
    assign memory_valid     = (state_q == DONE);
    assign memory_fault     = (state_q == DONE) && fault_q;
    assign memory_read_data = rdata_q;
    assign bus_write        = cmd_q;
    assign bus_address      = addr_q;
    assign bus_write_data   = wdata_q;
    assign bus_strobe       = strb_q;

endmodule
